// File: rtl/prog_loader_pkg.sv
// Shared types and framing constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_PAYLOAD,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int CSUM_BYTES     = 1;
  localparam int BYTES_PER_WORD = 4;

  // Total bytes on the wire for an image of the given word count.
  function automatic int frame_bytes(input int words);
    return HDR_BYTES + BYTES_PER_WORD * words + CSUM_BYTES;
  endfunction

  function automatic logic is_idle_like(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/prog_loader_word_packer.sv
// Assembles a stream of bytes into 32-bit little-endian words.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;

  // High on the load that completes a word; the full word is in the buffer next cycle.
  assign word_full = load && (idx == IDX_W'(BYTES_PER_WORD - 1));

  // Shifting in from the top leaves the first byte of a word at bits [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= '0;
    end else if (load) begin
      word <= {data, word[31:8]};
      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader that fills program memory and releases core reset on a good image.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t      state;
  logic [15:0] count;
  logic [7:0]  sum;
  logic        accept;
  logic        pack_load;
  logic        pack_clear;
  logic        word_full;
  logic [15:0] hdr_n;
  logic [15:0] words_written;
  logic [7:0]  csum_total;

  assign accept        = byte_valid && byte_ready;
  assign pack_load     = accept && (state == S_PAYLOAD);
  assign pack_clear    = start && is_idle_like(state);
  assign hdr_n         = {byte_data, count[7:0]};
  assign words_written = 16'(mem_addr) + 16'd1;
  assign csum_total    = sum + byte_data;

  // The packer buffer is itself a register, so it serves directly as the write data.
  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .load      (pack_load),
    .data      (byte_data),
    .word      (mem_wdata),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
      sum        <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_HDR_LO;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            mem_addr   <= '0;
            count      <= '0;
            sum        <= '0;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            count[7:0] <= byte_data;
            state      <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            count[15:8] <= byte_data;
            if (hdr_n == 16'd0) begin
              state <= S_CSUM;
            end else if (int'(hdr_n) > MAX_WORDS) begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
              core_rst_n <= 1'b0;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            sum <= csum_total;
            if (word_full) begin
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          mem_addr   <= mem_addr + 1'b1;
          byte_ready <= 1'b1;
          state      <= (words_written == count) ? S_CSUM : S_PAYLOAD;
        end
        S_CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (csum_total == 8'd0) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state      <= S_ERR;
              err        <= 1'b1;
              core_rst_n <= 1'b0;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad images, empty and oversize headers, reset and restart.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0]  wr_addr_log [0:31];
  logic [31:0] wr_data_log [0:31];
  int          wr_count = 0;

  logic [7:0]  frame [0:10];

  prog_loader #(.ADDR_W(10), .MAX_WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Records every program-memory write as seen by the memory.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_count < 32) begin
        wr_addr_log[wr_count] = mem_addr;
        wr_data_log[wr_count] = mem_wdata;
      end
      wr_count++;
    end
  end

  task automatic do_reset;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard;
    guard = 0;
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_data  = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame_bytes(input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) send_byte(frame[i], gap);
  endtask

  task automatic test_reset;
    do_reset();
    tests_run++;
    if ({byte_ready, mem_we, busy, done, err, core_rst_n} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b required 000000",
               {byte_ready, mem_we, busy, done, err, core_rst_n});
    end
    tests_run++;
    if (mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mem: addr=%h data=%h required 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_valid_image;
    int base;
    base = wr_count;
    frame[10] = 8'h4A;
    pulse_start();
    tests_run++;
    if (byte_ready !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_ready: ready=%b busy=%b required 1/1", byte_ready, busy);
    end
    send_frame_bytes(0, 5, 1'b0);
    tests_run++;
    if ({mem_we, byte_ready} !== 2'b10 || mem_addr !== 10'd0 || mem_wdata !== 32'h0000_0013) begin
      tests_failed++;
      $display("[TB] FAIL write0_timing: we=%b ready=%b addr=%h data=%h required 1/0/000/00000013",
               mem_we, byte_ready, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests_run++;
    if (byte_ready !== 1'b1 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ready_after_write: ready=%b we=%b required 1/0", byte_ready, mem_we);
    end
    send_frame_bytes(6, 10, 1'b0);
    tests_run++;
    if ({done, err, core_rst_n, busy} !== 4'b1010) begin
      tests_failed++;
      $display("[TB] FAIL valid_status: done/err/core_rst_n/busy=%b required 1010",
               {done, err, core_rst_n, busy});
    end
    tests_run++;
    if (wr_count - base !== 2 || wr_addr_log[base] !== 10'd0 || wr_data_log[base] !== 32'h0000_0013 ||
        wr_addr_log[base+1] !== 10'd1 || wr_data_log[base+1] !== 32'h0010_0093) begin
      tests_failed++;
      $display("[TB] FAIL valid_writes: n=%0d [%h]=%h [%h]=%h required 2 [000]=00000013 [001]=00100093",
               wr_count - base, wr_addr_log[base], wr_data_log[base],
               wr_addr_log[base+1], wr_data_log[base+1]);
    end
  endtask

  task automatic test_bad_checksum;
    int base;
    base = wr_count;
    frame[10] = 8'h00;
    pulse_start();
    tests_run++;
    if ({done, core_rst_n, busy} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL restart_from_done: done/core_rst_n/busy=%b required 001",
               {done, core_rst_n, busy});
    end
    send_frame_bytes(0, 10, 1'b0);
    tests_run++;
    if ({done, err, core_rst_n} !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL bad_csum_status: done/err/core_rst_n=%b required 010",
               {done, err, core_rst_n});
    end
    tests_run++;
    if (wr_count - base !== 2 || wr_data_log[base+1] !== 32'h0010_0093) begin
      tests_failed++;
      $display("[TB] FAIL bad_csum_writes: n=%0d last=%h required 2 00100093",
               wr_count - base, wr_data_log[base+1]);
    end
  endtask

  task automatic test_empty_image;
    int base;
    base = wr_count;
    pulse_start();
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_from_err: err=%b required 0", err);
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    tests_run++;
    if ({done, err, core_rst_n} !== 3'b101 || wr_count - base !== 0) begin
      tests_failed++;
      $display("[TB] FAIL empty_image: done/err/core_rst_n=%b writes=%0d required 101 0",
               {done, err, core_rst_n}, wr_count - base);
    end
  endtask

  task automatic test_length_limit;
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    tests_run++;
    if ({err, byte_ready, busy, core_rst_n} !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL oversize_hdr: err/ready/busy/core_rst_n=%b required 1000",
               {err, byte_ready, busy, core_rst_n});
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (wr_count - base !== 0) begin
      tests_failed++;
      $display("[TB] FAIL oversize_writes: n=%0d required 0", wr_count - base);
    end
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    tests_run++;
    if ({err, byte_ready, busy} !== 3'b011) begin
      tests_failed++;
      $display("[TB] FAIL max_words_hdr: err/ready/busy=%b required 011", {err, byte_ready, busy});
    end
  endtask

  task automatic test_reset_mid_session;
    int base;
    do_reset();
    base = wr_count;
    frame[10] = 8'h4A;
    pulse_start();
    send_frame_bytes(0, 7, 1'b1);
    tests_run++;
    if (wr_count - base !== 1) begin
      tests_failed++;
      $display("[TB] FAIL partial_writes: n=%0d required 1", wr_count - base);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({byte_ready, mem_we, busy, done, err, core_rst_n} !== 6'b0 ||
        mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL midsession_reset: flags=%b addr=%h data=%h required 000000/000/00000000",
               {byte_ready, mem_we, busy, done, err, core_rst_n}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = wr_count;
    pulse_start();
    send_frame_bytes(0, 10, 1'b0);
    tests_run++;
    if (done !== 1'b1 || wr_count - base !== 2 || wr_addr_log[base] !== 10'd0 ||
        wr_data_log[base] !== 32'h0000_0013 || wr_addr_log[base+1] !== 10'd1) begin
      tests_failed++;
      $display("[TB] FAIL reload_after_reset: done=%b n=%0d [%h]=%h next_addr=%h required 1 2 [000]=00000013 001",
               done, wr_count - base, wr_addr_log[base], wr_data_log[base], wr_addr_log[base+1]);
    end
  endtask

  task automatic test_start_during_payload;
    int base;
    base = wr_count;
    frame[10] = 8'h4A;
    pulse_start();
    send_frame_bytes(0, 3, 1'b0);
    pulse_start();
    tests_run++;
    if ({busy, byte_ready, err} !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL start_ignored: busy/ready/err=%b required 110", {busy, byte_ready, err});
    end
    send_frame_bytes(4, 10, 1'b0);
    tests_run++;
    if (done !== 1'b1 || err !== 1'b0 || wr_count - base !== 2 ||
        wr_data_log[base] !== 32'h0000_0013 || wr_data_log[base+1] !== 32'h0010_0093) begin
      tests_failed++;
      $display("[TB] FAIL payload_start_image: done=%b err=%b n=%0d w0=%h w1=%h required 1 0 2 00000013 00100093",
               done, err, wr_count - base, wr_data_log[base], wr_data_log[base+1]);
    end
  endtask

  initial begin
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h4A};
    test_reset();
    test_valid_image();
    test_bad_checksum();
    test_empty_image();
    test_length_limit();
    test_reset_mid_session();
    test_start_during_payload();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
